threshold_pixel_classifier: RTL

//   Consumer of the four 10-bit colour thresholds (red/blue for target 1 and target 2).

---
 rtl/threshold_pixel_classifier.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/threshold_pixel_classifier.sv
// threshold_pixel_classifier
//   Classifies each streamed pixel against two colour targets (red/blue thresholds per
//   target) in a 2-stage pipeline. It accumulates a match count and a bounding box per target
//   over each frame. On frame_end the per-frame results are published with a one-cycle
//   result_valid strobe.
//
// Ports
//   clk, reset                       clock, asynchronous active-high reset
//   frame_start, frame_end           frame delimiting strobes
//   pixel_valid, pixel_red/blue      pixel qualifier and colour channels
//   pixel_x, pixel_y                 pixel coordinates
//   red/blue_threshold_1/2           per-target thresholds, sampled on frame_start
//   result_valid                     one-cycle strobe: result outputs updated
//   found_k, count_k                 target k seen / saturating match count
//   min/max_x/y_k                    bounding box of target k matches
module threshold_pixel_classifier #(
  parameter int unsigned DATA_W  = 10,
  parameter int unsigned COORD_W = 10,
  parameter int unsigned COUNT_W = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               frame_end,
  input  logic               pixel_valid,
  input  logic [DATA_W-1:0]  pixel_red,
  input  logic [DATA_W-1:0]  pixel_blue,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic [DATA_W-1:0]  red_threshold_1,
  input  logic [DATA_W-1:0]  blue_threshold_1,
  input  logic [DATA_W-1:0]  red_threshold_2,
  input  logic [DATA_W-1:0]  blue_threshold_2,
  output logic               result_valid,
  output logic               found_1,
  output logic               found_2,
  output logic [COUNT_W-1:0] count_1,
  output logic [COUNT_W-1:0] count_2,
  output logic [COORD_W-1:0] min_x_1,
  output logic [COORD_W-1:0] max_x_1,
  output logic [COORD_W-1:0] min_y_1,
  output logic [COORD_W-1:0] max_y_1,
  output logic [COORD_W-1:0] min_x_2,
  output logic [COORD_W-1:0] max_x_2,
  output logic [COORD_W-1:0] min_y_2,
  output logic [COORD_W-1:0] max_y_2
);

  localparam logic [COUNT_W-1:0] CountMax = '1;
  localparam logic [COORD_W-1:0] CoordMax = '1;

  // Held thresholds, index 0 = target 1, index 1 = target 2
  logic [DATA_W-1:0] held_red_q  [2];
  logic [DATA_W-1:0] held_blue_q [2];
  logic [DATA_W-1:0] live_red    [2];
  logic [DATA_W-1:0] live_blue   [2];
  logic [DATA_W-1:0] thr_red     [2];
  logic [DATA_W-1:0] thr_blue    [2];
  logic [1:0]        match;

  // Stage 1 registers
  logic               s1_valid_q;
  logic               s1_eof_q;
  logic [COORD_W-1:0] s1_x_q;
  logic [COORD_W-1:0] s1_y_q;
  logic [1:0]         s1_match_q;

  // Stage 2 accumulators and their next state (accumulator plus the s1 pixel)
  logic [COUNT_W-1:0] acc_count_q [2];
  logic [COORD_W-1:0] acc_min_x_q [2];
  logic [COORD_W-1:0] acc_max_x_q [2];
  logic [COORD_W-1:0] acc_min_y_q [2];
  logic [COORD_W-1:0] acc_max_y_q [2];
  logic [COUNT_W-1:0] acc_count_d [2];
  logic [COORD_W-1:0] acc_min_x_d [2];
  logic [COORD_W-1:0] acc_max_x_d [2];
  logic [COORD_W-1:0] acc_min_y_d [2];
  logic [COORD_W-1:0] acc_max_y_d [2];

  // Published results
  logic               res_valid_q;
  logic [1:0]         res_found_q;
  logic [COUNT_W-1:0] res_count_q [2];
  logic [COORD_W-1:0] res_min_x_q [2];
  logic [COORD_W-1:0] res_max_x_q [2];
  logic [COORD_W-1:0] res_min_y_q [2];
  logic [COORD_W-1:0] res_max_y_q [2];

  assign live_red[0]  = red_threshold_1;
  assign live_red[1]  = red_threshold_2;
  assign live_blue[0] = blue_threshold_1;
  assign live_blue[1] = blue_threshold_2;

  // The frame_start pixel already belongs to the new frame, so it sees the live thresholds.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      thr_red[k]  = frame_start ? live_red[k]  : held_red_q[k];
      thr_blue[k] = frame_start ? live_blue[k] : held_blue_q[k];
      match[k]    = (pixel_red >= thr_red[k]) && (pixel_blue >= thr_blue[k]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        held_red_q[k]  <= '0;
        held_blue_q[k] <= '0;
      end
    end else if (frame_start) begin
      for (int k = 0; k < 2; k++) begin
        held_red_q[k]  <= live_red[k];
        held_blue_q[k] <= live_blue[k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_eof_q   <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_match_q <= '0;
    end else begin
      s1_valid_q <= pixel_valid;
      s1_eof_q   <= frame_end;
      s1_x_q     <= pixel_x;
      s1_y_q     <= pixel_y;
      s1_match_q <= pixel_valid ? match : 2'b00;
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      acc_count_d[k] = acc_count_q[k];
      acc_min_x_d[k] = acc_min_x_q[k];
      acc_max_x_d[k] = acc_max_x_q[k];
      acc_min_y_d[k] = acc_min_y_q[k];
      acc_max_y_d[k] = acc_max_y_q[k];
      if (s1_valid_q && s1_match_q[k]) begin
        if (acc_count_q[k] != CountMax) acc_count_d[k] = acc_count_q[k] + COUNT_W'(1);
        if (s1_x_q < acc_min_x_q[k]) acc_min_x_d[k] = s1_x_q;
        if (s1_x_q > acc_max_x_q[k]) acc_max_x_d[k] = s1_x_q;
        if (s1_y_q < acc_min_y_q[k]) acc_min_y_d[k] = s1_y_q;
        if (s1_y_q > acc_max_y_q[k]) acc_max_y_d[k] = s1_y_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid_q <= 1'b0;
      res_found_q <= '0;
      for (int k = 0; k < 2; k++) begin
        acc_count_q[k] <= '0;
        acc_min_x_q[k] <= CoordMax;
        acc_max_x_q[k] <= '0;
        acc_min_y_q[k] <= CoordMax;
        acc_max_y_q[k] <= '0;
        res_count_q[k] <= '0;
        res_min_x_q[k] <= '0;
        res_max_x_q[k] <= '0;
        res_min_y_q[k] <= '0;
        res_max_y_q[k] <= '0;
      end
    end else begin
      res_valid_q <= s1_eof_q;
      for (int k = 0; k < 2; k++) begin
        if (s1_eof_q) begin
          // Publish including the closing pixel, then restart empty.
          res_found_q[k] <= (acc_count_d[k] != '0);
          res_count_q[k] <= acc_count_d[k];
          res_min_x_q[k] <= acc_min_x_d[k];
          res_max_x_q[k] <= acc_max_x_d[k];
          res_min_y_q[k] <= acc_min_y_d[k];
          res_max_y_q[k] <= acc_max_y_d[k];
          acc_count_q[k] <= '0;
          acc_min_x_q[k] <= CoordMax;
          acc_max_x_q[k] <= '0;
          acc_min_y_q[k] <= CoordMax;
          acc_max_y_q[k] <= '0;
        end else begin
          acc_count_q[k] <= acc_count_d[k];
          acc_min_x_q[k] <= acc_min_x_d[k];
          acc_max_x_q[k] <= acc_max_x_d[k];
          acc_min_y_q[k] <= acc_min_y_d[k];
          acc_max_y_q[k] <= acc_max_y_d[k];
        end
      end
    end
  end

  assign result_valid = res_valid_q;
  assign found_1      = res_found_q[0];
  assign found_2      = res_found_q[1];
  assign count_1      = res_count_q[0];
  assign count_2      = res_count_q[1];
  assign min_x_1      = res_min_x_q[0];
  assign max_x_1      = res_max_x_q[0];
  assign min_y_1      = res_min_y_q[0];
  assign max_y_1      = res_max_y_q[0];
  assign min_x_2      = res_min_x_q[1];
  assign max_x_2      = res_max_x_q[1];
  assign min_y_2      = res_min_y_q[1];
  assign max_y_2      = res_max_y_q[1];

endmodule
